key_exp_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 12 +
 rtl/rk_store.sv | 33 +++
 rtl/key_exp_ctrl.sv | 159 +++++++++++++++
 tb/tb_key_exp_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the key-expansion controller and its store.
package aes_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_KEY_W = 128;

   typedef logic [AES_KEY_W-1:0] key_t;
   typedef logic [4:0]           round_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} key_ctrl_state_t;

endpackage

// File: rtl/rk_store.sv
// Round-key register file: one synchronous write port, one registered read port
// and one combinational read port. Out-of-range addresses read as zero.
module rk_store
   import aes_pkg::*;
#(
   parameter int DEPTH = AES_NR + 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       we,
   input  logic [3:0] waddr,
   input  key_t       wdata,
   input  logic [3:0] raddr,
   output key_t       rdata,
   input  logic [3:0] caddr,
   output key_t       cdata
);

   // Contents survive reset; only the read register is cleared.
   key_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && (32'(waddr) < DEPTH)) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdata <= '0;
      else          rdata <= (32'(raddr) < DEPTH) ? mem[raddr] : '0;
   end

   assign cdata = (32'(caddr) < DEPTH) ? mem[caddr] : '0;

endmodule

// File: rtl/key_exp_ctrl.sv
// AES-128 key-expansion sequencer: accepts a key, steps the datapath through rounds
// 1..NR and serves the stored round keys. Optional KEY_EXP_SKIP_EN skips re-expanding
// the most recently completed key.
//
//   state | meaning
//   IDLE  | no valid schedule, waiting for a key
//   ISSUE | exp_req strobe for the current round
//   WAIT  | waiting EXP_LAT cycles for the datapath result
//   DONE  | all NR+1 round keys stored, keys_valid high
module key_exp_ctrl
   import aes_pkg::*;
#(
   parameter int EXP_LAT = 1,
   parameter int NR      = AES_NR
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load_valid,
   input  key_t       load_key,
   output logic       load_ready,
   input  logic       abort,
   output logic       exp_req,
   output round_t     exp_round,
   output key_t       exp_key,
   input  key_t       exp_key_out,
   output logic       keys_valid,
   output logic       busy,
   input  logic [3:0] rd_round,
   output key_t       rd_key
);

   key_ctrl_state_t state, state_nxt;
   round_t          round, round_nxt;
   logic [2:0]      wait_cnt, wait_cnt_nxt;
   logic            keys_valid_nxt, busy_nxt;
   logic            we;
   logic [3:0]      waddr;
   key_t            wdata;
   logic            skip_hit;

   assign load_ready = (state == IDLE) || (state == DONE);
   assign exp_req    = (state == ISSUE);
   // round only moves on acceptance or WAIT->ISSUE, so it already holds the last issued value
   assign exp_round  = round;

   always_comb begin
      state_nxt      = state;
      round_nxt      = round;
      wait_cnt_nxt   = wait_cnt;
      keys_valid_nxt = keys_valid;
      busy_nxt       = busy;
      we             = 1'b0;
      waddr          = '0;
      wdata          = load_key;
      unique case (state)
         IDLE, DONE: begin
            if (load_valid) begin
               if (skip_hit) begin
                  state_nxt      = DONE;
                  keys_valid_nxt = 1'b1;
               end else begin
                  we             = 1'b1;
                  round_nxt      = round_t'(1);
                  keys_valid_nxt = 1'b0;
                  busy_nxt       = 1'b1;
                  state_nxt      = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (abort) begin
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               wait_cnt_nxt = 3'(EXP_LAT - 1);
               state_nxt    = WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (wait_cnt == '0) begin
               we    = 1'b1;
               waddr = round[3:0];
               wdata = exp_key_out;
               if (round == round_t'(NR)) begin
                  keys_valid_nxt = 1'b1;
                  busy_nxt       = 1'b0;
                  state_nxt      = DONE;
               end else begin
                  round_nxt = round + round_t'(1);
                  state_nxt = ISSUE;
               end
            end else begin
               wait_cnt_nxt = wait_cnt - 3'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         round      <= '0;
         wait_cnt   <= '0;
         keys_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         round      <= round_nxt;
         wait_cnt   <= wait_cnt_nxt;
         keys_valid <= keys_valid_nxt;
         busy       <= busy_nxt;
      end
   end

`ifdef KEY_EXP_SKIP_EN
   key_t last_key;
   logic match_vld;
   logic accept_full, done_entry, aborted;

   assign skip_hit    = match_vld && (load_key == last_key);
   assign accept_full = load_ready && load_valid && !skip_hit;
   assign done_entry  = (state == WAIT) && (state_nxt == DONE);
   assign aborted     = abort && ((state == ISSUE) || (state == WAIT));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_key  <= '0;
         match_vld <= 1'b0;
      end else begin
         if (accept_full) begin
            last_key  <= load_key;
            match_vld <= 1'b0;
         end
         if (done_entry) match_vld <= 1'b1;
         if (aborted)    match_vld <= 1'b0;
      end
   end
`else
   assign skip_hit = 1'b0;
`endif

   // Combinational port addresses rk[round-1]; round==0 after reset wraps out of range and reads 0.
   rk_store #(.DEPTH(NR + 1)) u_rk_store (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr   (rd_round),
      .rdata   (rd_key),
      .caddr   (4'(round - round_t'(1))),
      .cdata   (exp_key)
   );

endmodule

// File: tb/tb_key_exp_ctrl.sv
// Bench for key_exp_ctrl: AES key-schedule datapath model with configurable latency,
// random keys, abort/reset/load-collision cases, EXP_LAT=1 and EXP_LAT=4 instances.
module tb_key_exp_ctrl;
   import aes_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic [7:0] sb [256];

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv = 8'h00;
      if (x != 8'h00)
         for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic key_t next_rk(input key_t k, input logic [4:0] r);
      logic [31:0] w0, w1, w2, w3, t;
      logic [7:0]  rc = 8'h01;
      {w0, w1, w2, w3} = k;
      for (int i = 1; i < int'(r); i++) rc = xt(rc);
      t  = {w3[23:0], w3[31:24]};
      t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic key_t rnd_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- instance A: EXP_LAT = 1 ----------------
   logic       a_load_valid, a_load_ready, a_abort, a_exp_req, a_keys_valid, a_busy;
   key_t       a_load_key, a_exp_key, a_exp_key_out, a_rd_key;
   round_t     a_exp_round;
   logic [3:0] a_rd_round;

   key_exp_ctrl #(.EXP_LAT(1), .NR(10)) dut_a (
      .clk(clk), .reset_n(reset_n), .load_valid(a_load_valid), .load_key(a_load_key),
      .load_ready(a_load_ready), .abort(a_abort), .exp_req(a_exp_req),
      .exp_round(a_exp_round), .exp_key(a_exp_key), .exp_key_out(a_exp_key_out),
      .keys_valid(a_keys_valid), .busy(a_busy), .rd_round(a_rd_round), .rd_key(a_rd_key)
   );

   logic   a_req_s = 1'b0;
   key_t   a_key_s;
   round_t a_rnd_s;
   key_t   a_d;
   int     a_req_rnd[$];
   int     a_req_cyc[$];

   always @(negedge clk) begin
      a_req_s = a_exp_req;
      a_key_s = a_exp_key;
      a_rnd_s = a_exp_round;
      if (a_exp_req) begin
         a_req_rnd.push_back(int'(a_exp_round));
         a_req_cyc.push_back(cyc);
      end
   end
   // Result appears EXP_LAT edges after the strobe; garbage otherwise to expose early capture.
   always @(posedge clk) a_d <= a_req_s ? next_rk(a_key_s, a_rnd_s) : rnd_key();
   assign a_exp_key_out = a_d;

   // ---------------- instance B: EXP_LAT = 4 ----------------
   logic       b_load_valid, b_load_ready, b_abort, b_exp_req, b_keys_valid, b_busy;
   key_t       b_load_key, b_exp_key, b_exp_key_out, b_rd_key;
   round_t     b_exp_round;
   logic [3:0] b_rd_round;

   key_exp_ctrl #(.EXP_LAT(4), .NR(10)) dut_b (
      .clk(clk), .reset_n(reset_n), .load_valid(b_load_valid), .load_key(b_load_key),
      .load_ready(b_load_ready), .abort(b_abort), .exp_req(b_exp_req),
      .exp_round(b_exp_round), .exp_key(b_exp_key), .exp_key_out(b_exp_key_out),
      .keys_valid(b_keys_valid), .busy(b_busy), .rd_round(b_rd_round), .rd_key(b_rd_key)
   );

   logic   b_req_s = 1'b0;
   key_t   b_key_s;
   round_t b_rnd_s;
   key_t   b_d [4];
   int     b_req_rnd[$];
   int     b_req_cyc[$];

   always @(negedge clk) begin
      b_req_s = b_exp_req;
      b_key_s = b_exp_key;
      b_rnd_s = b_exp_round;
      if (b_exp_req) begin
         b_req_rnd.push_back(int'(b_exp_round));
         b_req_cyc.push_back(cyc);
      end
   end
   always @(posedge clk) begin
      b_d[0] <= b_req_s ? next_rk(b_key_s, b_rnd_s) : rnd_key();
      for (int i = 1; i < 4; i++) b_d[i] <= b_d[i-1];
   end
   assign b_exp_key_out = b_d[3];

   // ---------------- helpers (called at a negedge, return at a negedge) ----------------
   task automatic a_wait_kv(inout int n);
      while (!a_keys_valid && n < 300) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
   endtask

   task automatic a_load(input key_t k, output int n, output logic kv1);
      a_load_valid = 1'b1;
      a_load_key   = k;
      @(posedge clk); @(negedge clk);
      a_load_valid = 1'b0;
      kv1 = a_keys_valid;
      n   = 1;
      a_wait_kv(n);
   endtask

   task automatic a_read_all(input key_t k, input string tag);
      key_t exp_rk [16];
      exp_rk[0] = k;
      for (int r = 1; r <= 10; r++) exp_rk[r] = next_rk(exp_rk[r-1], 5'(r));
      for (int r = 11; r < 16; r++) exp_rk[r] = '0;
      for (int i = 0; i < 14; i++) begin
         int r = (i < 11) ? i : int'($urandom_range(0, 15));
         a_rd_round = 4'(r);
         @(posedge clk); @(negedge clk);
         chk($sformatf("%s_rd%0d", tag, r), a_rd_key, exp_rk[r]);
      end
   endtask

   task automatic a_check_reqs(input int lat, input string tag);
      chk({tag, "_req_cnt"}, 128'(a_req_rnd.size()), 128'(10));
      for (int i = 0; i < a_req_rnd.size(); i++) begin
         chk({tag, "_req_rnd"}, 128'(a_req_rnd[i]), 128'(i + 1));
         if (i > 0) chk({tag, "_req_gap"}, 128'(a_req_cyc[i] - a_req_cyc[i-1]), 128'(lat + 1));
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      key_t fips, k1, k2;
      int   n, cnt;
      logic kv1;

      for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
      fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      reset_n = 1'b0;
      a_load_valid = 1'b0; a_load_key = '0; a_abort = 1'b0; a_rd_round = '0;
      b_load_valid = 1'b0; b_load_key = '0; b_abort = 1'b0; b_rd_round = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_load_ready", 128'(a_load_ready), 128'(1));
      chk("rst_keys_valid", 128'(a_keys_valid), 128'(0));
      chk("rst_busy",       128'(a_busy), 128'(0));
      chk("rst_exp_req",    128'(a_exp_req), 128'(0));
      chk("rst_exp_round",  128'(a_exp_round), 128'(0));
      chk("rst_exp_key",    a_exp_key, '0);
      chk("rst_rd_key",     a_rd_key, '0);
      reset_n = 1'b1;
      @(negedge clk);

      // FIPS-197 key, EXP_LAT=1
      a_req_rnd.delete(); a_req_cyc.delete();
      a_load(fips, n, kv1);
      chk("fips_kv_cycle", 128'(n), 128'(21));
      chk("fips_busy_done", 128'(a_busy), 128'(0));
      chk("fips_ready_done", 128'(a_load_ready), 128'(1));
      a_check_reqs(1, "fips");
      a_rd_round = 4'd10;
      @(posedge clk); @(negedge clk);
      chk("fips_rk10", a_rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      a_rd_round = 4'd1;
      @(posedge clk); @(negedge clk);
      chk("fips_rk1", a_rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
      a_read_all(fips, "fips");

      // Random keys reloaded from DONE
      for (int t = 0; t < 3; t++) begin
         k1 = rnd_key();
         a_req_rnd.delete(); a_req_cyc.delete();
         a_load(k1, n, kv1);
         chk("rnd_kv_drop", 128'(kv1), 128'(0));
         chk("rnd_kv_cycle", 128'(n), 128'(21));
         a_check_reqs(1, "rnd");
         a_read_all(k1, "rnd");
      end

      // Abort on the 3rd exp_req
      k1 = rnd_key();
      a_load_valid = 1'b1; a_load_key = k1;
      cnt = 0;
      for (int i = 0; i < 100 && cnt < 3; i++) begin
         @(posedge clk); @(negedge clk);
         a_load_valid = 1'b0;
         if (a_exp_req) cnt++;
      end
      chk("abort_reached_req3", 128'(cnt), 128'(3));
      a_abort = 1'b1;
      @(posedge clk); @(negedge clk);
      a_abort = 1'b0;
      chk("abort_busy", 128'(a_busy), 128'(0));
      chk("abort_ready", 128'(a_load_ready), 128'(1));
      chk("abort_kv", 128'(a_keys_valid), 128'(0));
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (a_exp_req) cnt++;
      end
      chk("abort_no_req", 128'(cnt), 128'(0));
      chk("abort_kv_stays", 128'(a_keys_valid), 128'(0));
      k2 = rnd_key();
      a_req_rnd.delete(); a_req_cyc.delete();
      a_load(k2, n, kv1);
      chk("post_abort_kv_cycle", 128'(n), 128'(21));
      a_check_reqs(1, "post_abort");
      a_read_all(k2, "post_abort");

      // load_valid held high through ISSUE/WAIT is ignored
      k1 = rnd_key();
      k2 = rnd_key();
      a_load_valid = 1'b1; a_load_key = k1;
      @(posedge clk); @(negedge clk);
      a_load_key = k2;
      n = 1;
      for (int i = 0; i < 6; i++) begin
         chk("hold_ready_low", 128'(a_load_ready), 128'(0));
         @(posedge clk); @(negedge clk);
         n++;
      end
      a_load_valid = 1'b0;
      a_wait_kv(n);
      chk("hold_kv_cycle", 128'(n), 128'(21));
      a_read_all(k1, "hold");

      // load and abort together in DONE: load wins
      k2 = rnd_key();
      a_load_valid = 1'b1; a_abort = 1'b1; a_load_key = k2;
      @(posedge clk); @(negedge clk);
      a_load_valid = 1'b0; a_abort = 1'b0;
      chk("ld_abort_busy", 128'(a_busy), 128'(1));
      chk("ld_abort_kv", 128'(a_keys_valid), 128'(0));
      n = 1;
      a_wait_kv(n);
      chk("ld_abort_kv_cycle", 128'(n), 128'(21));
      a_read_all(k2, "ld_abort");

      // Asynchronous reset in the middle of WAIT
      k1 = rnd_key();
      a_load_valid = 1'b1; a_load_key = k1;
      @(posedge clk); @(negedge clk);
      a_load_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_kv", 128'(a_keys_valid), 128'(0));
      chk("mrst_ready", 128'(a_load_ready), 128'(1));
      chk("mrst_busy", 128'(a_busy), 128'(0));
      chk("mrst_exp_req", 128'(a_exp_req), 128'(0));
      chk("mrst_exp_round", 128'(a_exp_round), 128'(0));
      chk("mrst_rd_key", a_rd_key, '0);
      @(negedge clk);
      reset_n = 1'b1;
      a_rd_round = 4'd11;
      @(posedge clk); @(negedge clk);
      chk("mrst_rd11", a_rd_key, '0);
      a_rd_round = 4'd0;
      @(posedge clk); @(negedge clk);
      chk("mrst_rd0_kept", a_rd_key, k1);

      // Reset from DONE clears keys_valid although the store is intact
      k2 = rnd_key();
      a_load(k2, n, kv1);
      chk("done_kv_cycle", 128'(n), 128'(21));
      #2 reset_n = 1'b0;
      #1 chk("done_rst_kv", 128'(a_keys_valid), 128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

`ifdef KEY_EXP_SKIP_EN
      k1 = rnd_key();
      a_load(k1, n, kv1);
      chk("skip_first_cycle", 128'(n), 128'(21));
      a_req_rnd.delete(); a_req_cyc.delete();
      a_load(k1, n, kv1);
      chk("skip_kv_next", 128'(kv1), 128'(1));
      for (int i = 0; i < 5; i++) begin @(posedge clk); @(negedge clk); end
      chk("skip_no_req", 128'(a_req_rnd.size()), 128'(0));
      chk("skip_busy", 128'(a_busy), 128'(0));
      a_read_all(k1, "skip");
      k2 = rnd_key();
      a_load(k2, n, kv1);
      chk("skip_diff_cycle", 128'(n), 128'(21));
      a_check_reqs(1, "skip_diff");
      a_read_all(k2, "skip_diff");
`endif

      // EXP_LAT=4 instance
      b_req_rnd.delete(); b_req_cyc.delete();
      b_load_valid = 1'b1; b_load_key = fips;
      @(posedge clk); @(negedge clk);
      b_load_valid = 1'b0;
      n = 1;
      while (!b_keys_valid && n < 300) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      chk("lat4_kv_cycle", 128'(n), 128'(51));
      chk("lat4_req_cnt", 128'(b_req_rnd.size()), 128'(10));
      for (int i = 0; i < b_req_rnd.size(); i++) begin
         chk("lat4_req_rnd", 128'(b_req_rnd[i]), 128'(i + 1));
         if (i > 0) chk("lat4_req_gap", 128'(b_req_cyc[i] - b_req_cyc[i-1]), 128'(5));
      end
      b_rd_round = 4'd10;
      @(posedge clk); @(negedge clk);
      chk("lat4_rk10", b_rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      b_rd_round = 4'd1;
      @(posedge clk); @(negedge clk);
      chk("lat4_rk1", b_rd_key, 128'ha0fafe1788542cb123a339392a6c7605);

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
